// File: rtl/fetch_pkg.sv
// Shared types, constants and helpers for the instruction fetch buffer.
package fetch_pkg;

    typedef logic [15:0] instr_word_t;

    localparam instr_word_t NOP_WORD_DEFAULT = 16'h0000;

    // Circular-buffer pointer increment with wrap at depth-1 (any depth, not only powers of two).
    function automatic int unsigned calc_ptr_next(input int unsigned ptr, input int unsigned depth);
        return (ptr >= depth - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/fetch_fifo_ram.sv
// DEPTH x DATA_WIDTH register array: synchronous write, asynchronous read.
module fetch_fifo_ram #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 2,
    localparam int unsigned AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_buffer.sv
// Instruction prefetch buffer between program cache and decoder, with flush,
// hazard hold and pc_hold back-pressure that reserves a slot for the in-flight word.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 16,
    parameter int unsigned           DEPTH      = 2,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD   = DATA_WIDTH'(NOP_WORD_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  p_valid,
    input  logic                  hazard,
    input  logic                  decoder_rst,
    output logic [DATA_WIDTH-1:0] instruction_out,
    output logic                  instruction_valid,
    output logic                  pc_hold,
    output logic                  overflow
);

    localparam int unsigned   CW   = $clog2(DEPTH + 1);
    localparam int unsigned   PW   = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [CW-1:0]         count, count_next;
    logic [PW-1:0]         rd_ptr, rd_ptr_next, wr_ptr, wr_ptr_next;
    logic                  push, pop, wr_en, ovf_event;
    logic                  valid_next, overflow_next;
    logic [CW:0]           occupancy;
    logic [DATA_WIDTH-1:0] ram_rdata, head_next;

    fetch_fifo_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH)
    ) u_ram (
        .clk  (clk),
        .we   (wr_en),
        .waddr(wr_ptr),
        .wdata(p_data),
        .raddr(rd_ptr_next),
        .rdata(ram_rdata)
    );

    // Control: push/pop qualification, pointer/count update, back-pressure.
    always_comb begin
        push          = p_valid & ~decoder_rst;
        pop           = instruction_valid & ~hazard & ~decoder_rst;
        wr_en         = ~rst & push & ((count != FULL) | pop);
        ovf_event     = push & (count == FULL) & ~pop;
        count_next    = count;
        rd_ptr_next   = rd_ptr;
        wr_ptr_next   = wr_ptr;
        overflow_next = overflow | ovf_event;

        if (decoder_rst) begin
            count_next  = '0;
            rd_ptr_next = '0;
            wr_ptr_next = '0;
        end else begin
            if (pop) begin
                rd_ptr_next = PW'(calc_ptr_next(32'(rd_ptr), DEPTH));
            end
            if (wr_en) begin
                wr_ptr_next = PW'(calc_ptr_next(32'(wr_ptr), DEPTH));
            end
            if (wr_en && !pop) begin
                count_next = count + CW'(1);
            end else if (pop && !wr_en) begin
                count_next = count - CW'(1);
            end
        end

        valid_next = (count_next != '0);
        occupancy  = {1'b0, count} + (CW + 1)'(push) - (CW + 1)'(pop);
        pc_hold    = rst | (occupancy >= (CW + 1)'(DEPTH));
    end

    // Post-edge head: a word written this cycle into the slot that becomes head bypasses the array.
    always_comb begin
        head_next = NOP_WORD;
        if (valid_next) begin
            head_next = (wr_en && (rd_ptr_next == wr_ptr)) ? p_data : ram_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count             <= '0;
            rd_ptr            <= '0;
            wr_ptr            <= '0;
            overflow          <= 1'b0;
            instruction_out   <= NOP_WORD;
            instruction_valid <= 1'b0;
        end else begin
            count             <= count_next;
            rd_ptr            <= rd_ptr_next;
            wr_ptr            <= wr_ptr_next;
            overflow          <= overflow_next;
            instruction_out   <= head_next;
            instruction_valid <= valid_next;
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// Scoreboard bench for fetch_buffer: directed scenarios followed by randomized traffic
// against a queue-based reference model.
module tb_fetch_buffer;

    localparam int unsigned DEPTH = 2;

    typedef struct packed {
        logic        v;
        logic [15:0] d;
        logic        o;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, p_valid, hazard, decoder_rst;
    logic [15:0] p_data;
    logic [15:0] instruction_out;
    logic        instruction_valid, pc_hold, overflow;

    int checks   = 0;
    int failures = 0;

    logic [15:0] mq[$];
    bit          movf = 1'b0;
    exp_t        exp_q[$];

    fetch_buffer #(
        .DATA_WIDTH(16),
        .DEPTH     (DEPTH),
        .NOP_WORD  (16'h0000)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .p_data           (p_data),
        .p_valid          (p_valid),
        .hazard           (hazard),
        .decoder_rst      (decoder_rst),
        .instruction_out  (instruction_out),
        .instruction_valid(instruction_valid),
        .pc_hold          (pc_hold),
        .overflow         (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s at %0t: got=%h expected=%h", name, $time, act, req);
        end
    endtask

    function automatic bit model_hold(input bit r, input bit v, input bit h, input bit f);
        int occ;
        occ = mq.size() + ((v && !f) ? 1 : 0) - ((mq.size() > 0 && !h && !f) ? 1 : 0);
        return r || (occ >= int'(DEPTH));
    endfunction

    // Reference model: a word queue, updated once per clock edge.
    function automatic void model_step(input bit r, input bit v, input logic [15:0] d,
                                       input bit h, input bit f);
        bit   pp, ok;
        exp_t e;
        if (r) begin
            mq.delete();
            movf = 1'b0;
        end else if (f) begin
            mq.delete();
        end else begin
            pp = (mq.size() > 0) && !h;
            ok = v && ((mq.size() < int'(DEPTH)) || pp);
            if (v && !ok) movf = 1'b1;
            if (pp) void'(mq.pop_front());
            if (ok) mq.push_back(d);
        end
        e.v = (mq.size() > 0);
        e.d = (mq.size() > 0) ? mq[0] : 16'h0000;
        e.o = movf;
        exp_q.push_back(e);
    endfunction

    // One clock cycle: drive, check combinational pc_hold, advance model at the edge.
    task automatic cycle(input bit r, input bit v, input logic [15:0] d, input bit h, input bit f);
        bit eh;
        rst = r; p_valid = v; p_data = d; hazard = h; decoder_rst = f;
        eh = model_hold(r, v, h, f);
        #1;
        check("pc_hold", 16'(pc_hold), 16'(eh));
        @(posedge clk);
        model_step(r, v, d, h, f);
        #2;
    endtask

    // Monitor: compares registered outputs with the scoreboard once per cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("instruction_valid", 16'(instruction_valid), 16'(e.v));
                check("instruction_out", instruction_out, e.d);
                check("overflow", 16'(overflow), 16'(e.o));
            end
        end
    end

    initial begin
        bit issued;
        bit r, v, h, f;
        logic [15:0] d;
        rst = 1'b1; p_valid = 1'b0; hazard = 1'b0; decoder_rst = 1'b0; p_data = '0;
        @(posedge clk);
        #2;

        // Reset then stream
        cycle(1, 0, 16'h0, 0, 0);
        cycle(1, 0, 16'h0, 0, 0);
        cycle(0, 1, 16'h1001, 0, 0);
        cycle(0, 1, 16'h1002, 0, 0);
        cycle(0, 1, 16'h1003, 0, 0);
        cycle(0, 0, 16'h0, 0, 0);
        cycle(0, 0, 16'h0, 0, 0);

        // Hazard stall
        cycle(0, 1, 16'hA000, 0, 0);
        cycle(0, 1, 16'hA001, 1, 0);
        cycle(0, 1, 16'hA002, 1, 0);
        cycle(0, 0, 16'h0, 1, 0);
        cycle(0, 0, 16'h0, 1, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 16'h0, 0, 0);

        // Flush mid-stream
        cycle(0, 1, 16'hB000, 1, 0);
        cycle(0, 1, 16'hB001, 1, 0);
        cycle(0, 1, 16'hB002, 1, 1);
        cycle(0, 1, 16'hC000, 1, 0);
        cycle(0, 0, 16'h0, 0, 0);
        cycle(0, 0, 16'h0, 0, 0);

        // Simultaneous push/pop at full
        cycle(0, 1, 16'hD000, 1, 0);
        cycle(0, 1, 16'hD001, 1, 0);
        cycle(0, 1, 16'hD002, 0, 0);
        cycle(0, 1, 16'hD003, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 16'h0, 0, 0);

        // Overflow, sticky until reset
        cycle(0, 1, 16'hE000, 1, 0);
        cycle(0, 1, 16'hE001, 1, 0);
        cycle(0, 1, 16'hE002, 1, 0);
        cycle(0, 0, 16'h0, 1, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 16'h0, 0, 0);

        // Reset mid-operation
        cycle(0, 1, 16'hF000, 1, 0);
        cycle(0, 1, 16'hF001, 1, 0);
        cycle(1, 0, 16'h0, 1, 0);
        cycle(0, 0, 16'h0, 0, 0);

        // Randomized traffic; the fetch source mostly honours pc_hold
        issued = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 199) == 0);
            f = ($urandom_range(0, 19) == 0);
            h = ($urandom_range(0, 2) == 0);
            v = issued || ($urandom_range(0, 29) == 0);
            d = 16'($urandom);
            issued = !model_hold(r, v, h, f) && ($urandom_range(0, 3) != 0);
            cycle(r, v, d, h, f);
        end

        cycle(0, 0, 16'h0, 0, 0);
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got=%0d pending expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
